// File: rtl/tx_frame_gen.sv
// tx_frame_gen: serial frame transmitter (start, LSB-first data, optional parity, stop bits)
// with a mid-bit companion bit clock, valid/ready intake and back-to-back repeat mode.
module tx_frame_gen #(
  parameter int CLK_DIV    = 12500,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  input  logic              repeat_en,
  output logic              tx_out,
  output logic              bit_clk,
  output logic              busy,
  output logic [7:0]        frame_count
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t            state_q;
  logic [DW-1:0]     div_q, div_d;
  logic [DATA_W-1:0] pay_q, sh_q;
  logic [IW-1:0]     idx_q;
  logic              stop_q;
  logic              tick, par;
  assign tick  = div_q == DIV_LAST;
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign par   = (^pay_q) ^ (PARITY_ODD != 0);
  assign ready = state_q == IDLE;
  assign busy  = state_q != IDLE;
  // bit_clk follows the next divider value so it falls on the same edge tx_out moves
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_clk     <= 1'b0;
      pay_q       <= '0;
      sh_q        <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      tx_out      <= 1'b1;
      frame_count <= '0;
    end else begin
      div_q   <= div_d;
      bit_clk <= div_d >= DIV_HALF;
      if (state_q == IDLE) begin
        if (valid) begin
          pay_q   <= data;
          state_q <= WAIT;
        end
      end else if (tick) begin
        case (state_q)
          WAIT: begin
            tx_out  <= 1'b0;
            state_q <= START;
          end
          START: begin
            tx_out  <= pay_q[0];
            sh_q    <= pay_q >> 1;
            idx_q   <= '0;
            state_q <= DATA;
          end
          DATA: begin
            if (idx_q < IDX_LAST) begin
              tx_out <= sh_q[0];
              sh_q   <= sh_q >> 1;
              idx_q  <= idx_q + 1'b1;
            end else begin
              tx_out  <= PARITY_EN != 0 ? par : 1'b1;
              state_q <= PARITY_EN != 0 ? PARITY : STOP;
              stop_q  <= 1'b0;
            end
          end
          PARITY: begin
            tx_out  <= 1'b1;
            state_q <= STOP;
            stop_q  <= 1'b0;
          end
          STOP: begin
            if (stop_q == STOP_LAST) begin
              frame_count <= frame_count + 1'b1;
              tx_out      <= !repeat_en;
              state_q     <= repeat_en ? START : IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_frame_gen.sv
// tb_tx_frame_gen: three transmitter variants (even parity, odd parity, no parity + 2 stops)
// whose line output is decoded by per-instance monitors against a queue of expected frames.
module tb_tx_frame_gen;
  localparam int NI = 3;
  localparam int BIG = 100000;
  typedef struct packed {
    logic [10:0] fr;
    int          mn;
    int          mx;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_r[NI];
  logic       valid_r[NI];
  logic       rpt_r[NI];
  logic       rdy_w[NI];
  logic       tx_w[NI];
  logic       bc_w[NI];
  logic       busy_w[NI];
  logic [7:0] fc_w[NI];
  exp_t       exp_q[NI][$];
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  tx_frame_gen #(.CLK_DIV(8), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .CLOCK_50(clk), .RESET(rst), .data(data_r[0]), .valid(valid_r[0]), .ready(rdy_w[0]),
    .repeat_en(rpt_r[0]), .tx_out(tx_w[0]), .bit_clk(bc_w[0]), .busy(busy_w[0]), .frame_count(fc_w[0]));
  tx_frame_gen #(.CLK_DIV(8), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .CLOCK_50(clk), .RESET(rst), .data(data_r[1]), .valid(valid_r[1]), .ready(rdy_w[1]),
    .repeat_en(rpt_r[1]), .tx_out(tx_w[1]), .bit_clk(bc_w[1]), .busy(busy_w[1]), .frame_count(fc_w[1]));
  tx_frame_gen #(.CLK_DIV(8), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_nopar (
    .CLOCK_50(clk), .RESET(rst), .data(data_r[2]), .valid(valid_r[2]), .ready(rdy_w[2]),
    .repeat_en(rpt_r[2]), .tx_out(tx_w[2]), .bit_clk(bc_w[2]), .busy(busy_w[2]), .frame_count(fc_w[2]));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic push(input int i, input logic [10:0] fr, input int mn, input int mx);
    exp_t e;
    e.fr = fr;
    e.mn = mn;
    e.mx = mx;
    exp_q[i].push_back(e);
  endtask
  task automatic send(input int i, input logic [7:0] d);
    int n = 0;
    while (!rdy_w[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_w[i]) chk("send_ready_timeout", 32'(rdy_w[i]), 32'd1);
    data_r[i]  = d;
    valid_r[i] = 1'b1;
    @(negedge clk);
    valid_r[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    while (busy_w[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[i]) chk("idle_timeout", 32'(busy_w[i]), 32'd0);
  endtask
  task automatic wait_fc(input int i, input logic [7:0] v);
    int n = 0;
    while (fc_w[i] !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (fc_w[i] !== v) chk("frame_count_timeout", 32'(fc_w[i]), 32'(v));
  endtask
  task automatic wait_start(input int i);
    int n = 0;
    while (tx_w[i] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_w[i] !== 1'b0) chk("start_timeout", 32'(tx_w[i]), 32'd0);
  endtask
  // each monitor decodes 11 bit periods from a 1->0 edge, checking every bit holds for
  // 8 cycles with bit_clk low for the first half and high for the second
  for (genvar g = 0; g < NI; g++) begin : mon
    initial begin
      logic        prev, ok, ab;
      logic [10:0] fr;
      int          idle;
      exp_t        e;
      prev = 1'b1;
      idle = BIG;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev = 1'b1;
          idle = BIG;
        end else if (prev && !tx_w[g]) begin
          fr = '0;
          ok = 1'b1;
          ab = 1'b0;
          for (int b = 0; b < 11 && !ab; b++) begin
            for (int c = 0; c < 8 && !ab; c++) begin
              if (b > 0 || c > 0) @(negedge clk);
              if (rst) ab = 1'b1;
              else begin
                if (c == 0) fr[b] = tx_w[g];
                else if (tx_w[g] !== fr[b]) ok = 1'b0;
                if (bc_w[g] !== (c >= 4)) ok = 1'b0;
              end
            end
          end
          if (ab) begin
            prev = 1'b1;
            idle = BIG;
          end else begin
            checks++;
            if (exp_q[g].size() == 0) begin
              errors++;
              $display("FAIL unexpected_frame inst%0d: got %03h expected none", g, fr);
            end else begin
              e = exp_q[g].pop_front();
              if (fr !== e.fr || !ok || idle < e.mn || idle > e.mx) begin
                errors++;
                $display("FAIL frame inst%0d: got %03h timing_ok=%0d idle=%0d expected %03h idle %0d..%0d",
                         g, fr, ok, idle, e.fr, e.mn, e.mx);
              end
            end
            prev = fr[10];
            idle = 0;
          end
        end else begin
          prev = tx_w[g];
          if (tx_w[g] && idle < BIG) idle++;
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < NI; i++) begin
      data_r[i]  = '0;
      valid_r[i] = 1'b0;
      rpt_r[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_tx", 32'(tx_w[i]), 32'd1);
      chk("reset_bitclk", 32'(bc_w[i]), 32'd0);
      chk("reset_busy", 32'(busy_w[i]), 32'd0);
      chk("reset_ready", 32'(rdy_w[i]), 32'd1);
      chk("reset_fc", 32'(fc_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    push(1, {2'b10, 8'h07, 1'b0}, 0, BIG);
    send(1, 8'h07);
    push(2, {2'b11, 8'h5A, 1'b0}, 0, BIG);
    send(2, 8'h5A);
    push(0, {2'b10, 8'hA5, 1'b0}, 0, BIG);
    send(0, 8'hA5);
    chk("busy_after_accept", 32'(busy_w[0]), 32'd1);
    for (int i = 0; i < NI; i++) begin
      wait_idle(i);
      chk("fc_first_frame", 32'(fc_w[i]), 32'd1);
      chk("ready_after_frame", 32'(rdy_w[i]), 32'd1);
    end
    push(0, {2'b11, 8'h07, 1'b0}, 0, BIG);
    send(0, 8'h07);
    wait_idle(0);
    chk("fc_even07", 32'(fc_w[0]), 32'd2);
    rpt_r[0] = 1'b1;
    push(0, {2'b10, 8'h3C, 1'b0}, 0, BIG);
    for (int k = 0; k < 3; k++) push(0, {2'b10, 8'h3C, 1'b0}, 0, 0);
    send(0, 8'h3C);
    data_r[0] = 8'hFF;
    wait_fc(0, 8'd5);
    chk("repeat_busy", 32'(busy_w[0]), 32'd1);
    chk("repeat_fc3", 32'(fc_w[0]), 32'd5);
    repeat (40) @(negedge clk);
    rpt_r[0] = 1'b0;
    wait_idle(0);
    chk("repeat_fc4", 32'(fc_w[0]), 32'd6);
    chk("repeat_ready", 32'(rdy_w[0]), 32'd1);
    push(0, {2'b10, 8'h81, 1'b0}, 0, BIG);
    push(0, {2'b10, 8'h42, 1'b0}, 8, 8);
    send(0, 8'h81);
    wait_start(0);
    repeat (20) @(negedge clk);
    chk("ready_in_data", 32'(rdy_w[0]), 32'd0);
    data_r[0]  = 8'hFF;
    valid_r[0] = 1'b1;
    @(negedge clk);
    valid_r[0] = 1'b0;
    send(0, 8'h42);
    wait_idle(0);
    chk("fc_b2b", 32'(fc_w[0]), 32'd8);
    send(0, 8'h00);
    wait_start(0);
    repeat (44) @(negedge clk);
    chk("pre_reset_tx", 32'(tx_w[0]), 32'd0);
    chk("pre_reset_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_tx", 32'(tx_w[0]), 32'd1);
    chk("midreset_bitclk", 32'(bc_w[0]), 32'd0);
    chk("midreset_fc", 32'(fc_w[0]), 32'd0);
    chk("midreset_ready", 32'(rdy_w[0]), 32'd1);
    chk("midreset_busy", 32'(busy_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(0, {2'b10, 8'h5A, 1'b0}, 0, BIG);
    send(0, 8'h5A);
    wait_idle(0);
    chk("fc_after_reset", 32'(fc_w[0]), 32'd1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("pending_frames", 32'(exp_q[i].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
